alu_cmd_sequencer: RTL

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_seq_pkg.sv | 33 +++
 rtl/alu_cmd_sequencer_if.sv | 35 +++
 rtl/alu_cmd_fifo.sv | 78 +++++++
 rtl/alu_cmd_sequencer.sv | 128 ++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM encoding,
// and the packed command word stored in the queue.
package alu_seq_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int CMD_W = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } seq_state_e;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    function automatic cmd_t make_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        cmd_t c;
        c.op = op;
        c.a  = a;
        c.b  = b;
        return c;
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU and response signals of the sequencer bundled as one interface;
// slave is the sequencer view, master the environment view.
interface alu_cmd_sequencer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_opcode;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       alu_start;
    logic [1:0] alu_opcode;
    logic [7:0] alu_inbus_a;
    logic [7:0] alu_inbus_b;
    logic [7:0] alu_outbus;
    logic       alu_done;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [1:0] rsp_opcode;
    logic       rsp_timeout;
    logic       busy;

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_outbus, alu_done, rsp_ready,
        output cmd_ready, alu_start, alu_opcode, alu_inbus_a, alu_inbus_b,
               rsp_valid, rsp_data, rsp_opcode, rsp_timeout, busy
    );

    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_outbus, alu_done, rsp_ready,
        input  cmd_ready, alu_start, alu_opcode, alu_inbus_a, alu_inbus_b,
               rsp_valid, rsp_data, rsp_opcode, rsp_timeout, busy
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command queue, DEPTH entries of CMD_W bits; head is visible on
// dout_o whenever the queue is non-empty.
module alu_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [CMD_W-1:0]       din_i,
    input  logic                   pop_i,
    output logic [CMD_W-1:0]       dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign count_o   = count_q;
    assign dout_o    = mem_q[rd_ptr_q];
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;

    // Next-state pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, issues them one at a time to a multi-cycle ALU and
// returns each result (or a timeout abort) over a valid/ready response port.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                clk,
    input  logic                reset,
    alu_cmd_sequencer_if.slave  bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    seq_state_e                  state_q;
    logic                        alu_start_q;
    logic [1:0]                  alu_opcode_q;
    logic [7:0]                  alu_a_q;
    logic [7:0]                  alu_b_q;
    logic [CNT_W-1:0]            wait_cnt_q;
    logic                        rsp_valid_q;
    logic [7:0]                  rsp_data_q;
    logic [1:0]                  rsp_opcode_q;
    logic                        rsp_timeout_q;

    logic                        fifo_push_s;
    logic                        fifo_pop_s;
    logic                        fifo_full_s;
    logic                        fifo_empty_s;
    logic [CMD_W-1:0]            fifo_dout_s;
    logic [$clog2(FIFO_DEPTH):0] fifo_count_s;
    cmd_t                        head_s;

    assign bus.cmd_ready = !fifo_full_s;
    assign fifo_push_s   = bus.cmd_valid && !fifo_full_s;
    assign fifo_pop_s    = (state_q == ST_IDLE) && !fifo_empty_s;
    assign head_s        = cmd_t'(fifo_dout_s);

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push_s),
        .din_i   (make_cmd(bus.cmd_opcode, bus.cmd_a, bus.cmd_b)),
        .pop_i   (fifo_pop_s),
        .dout_o  (fifo_dout_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // Issue/wait/respond controller; wait_cnt_q numbers the current WAIT cycle from 1,
    // so a done seen while it is 1 is the previous operation's stale level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            alu_start_q   <= 1'b0;
            alu_opcode_q  <= 2'b00;
            alu_a_q       <= 8'h00;
            alu_b_q       <= 8'h00;
            wait_cnt_q    <= {CNT_W{1'b0}};
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= 8'h00;
            rsp_opcode_q  <= 2'b00;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        state_q      <= ST_ISSUE;
                        alu_start_q  <= 1'b1;
                        alu_opcode_q <= head_s.op;
                        alu_a_q      <= head_s.a;
                        alu_b_q      <= head_s.b;
                    end
                end
                ST_ISSUE: begin
                    state_q     <= ST_WAIT;
                    alu_start_q <= 1'b0;
                    wait_cnt_q  <= CNT_W'(1);
                end
                ST_WAIT: begin
                    if (bus.alu_done && (wait_cnt_q > CNT_W'(1))) begin
                        state_q       <= ST_RESP;
                        rsp_valid_q   <= 1'b1;
                        rsp_data_q    <= bus.alu_outbus;
                        rsp_opcode_q  <= alu_opcode_q;
                        rsp_timeout_q <= 1'b0;
                        wait_cnt_q    <= {CNT_W{1'b0}};
                    end else if (wait_cnt_q >= CNT_W'(TIMEOUT)) begin
                        state_q       <= ST_RESP;
                        rsp_valid_q   <= 1'b1;
                        rsp_data_q    <= 8'h00;
                        rsp_opcode_q  <= alu_opcode_q;
                        rsp_timeout_q <= 1'b1;
                        wait_cnt_q    <= {CNT_W{1'b0}};
                    end else begin
                        wait_cnt_q    <= wait_cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    alu_start_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.alu_start   = alu_start_q;
    assign bus.alu_opcode  = alu_opcode_q;
    assign bus.alu_inbus_a = alu_a_q;
    assign bus.alu_inbus_b = alu_b_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_opcode  = rsp_opcode_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.busy        = (state_q != ST_IDLE) || (fifo_count_s != '0);

endmodule
